ddr_frame_reader: RTL

DDR_FRAME_READER -- requirements
Module: ddr_frame_reader

---
 rtl/ddr_pkg.sv | 28 ++
 rtl/ddr_rd_fifo.sv | 66 ++++++
 rtl/ddr_frame_reader.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/ddr_pkg.sv
// Shared DDR read/write definitions: bus widths, FSM states, AR payload and address stepping.
package ddr_pkg;

    localparam int unsigned DDR_ADDR_W          = 28;
    localparam int unsigned DDR_DATA_W          = 256;
    localparam int unsigned DDR_LEN_W           = 4;
    localparam int unsigned DDR_ID_W            = 4;
    localparam int unsigned DDR_BEAT_ADDR_SCALE = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } ddr_state_t;

    typedef struct packed {
        logic [DDR_ADDR_W-1:0] addr;
        logic [DDR_LEN_W-1:0]  len;
        logic [DDR_ID_W-1:0]   user_id;
    } ddr_ar_t;

    // One 256-bit beat spans eight 32-bit DDR words; the sum wraps at 2^28.
    function automatic logic [DDR_ADDR_W-1:0] ddr_burst_step(input logic [DDR_LEN_W:0] beats);
        return DDR_ADDR_W'(beats) * DDR_ADDR_W'(DDR_BEAT_ADDR_SCALE);
    endfunction

endpackage

// File: rtl/ddr_rd_fifo.sv
// Single-clock output buffer for read beats; registered empty/full/free status.
module ddr_rd_fifo #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned WIDTH = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] free,
    output logic                       overflow_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             do_push_c;
    logic             do_pop_c;

    // A pop frees the slot the simultaneous push needs, so full+pop+push is legal.
    assign do_pop_c   = pop && !empty;
    assign do_push_c  = push && (!full || do_pop_c);
    assign overflow_c = push && full && !do_pop_c;
    assign rd_data    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({do_push_c, do_pop_c})
            2'b10:   count_next = CW'(count + CW'(1));
            2'b01:   count_next = CW'(count - CW'(1));
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            free   <= CW'(DEPTH);
        end else begin
            if (do_push_c) wr_ptr <= AW'(wr_ptr + AW'(1));
            if (do_pop_c)  rd_ptr <= AW'(rd_ptr + AW'(1));
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == CW'(DEPTH));
            free  <= CW'(CW'(DEPTH) - count_next);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push_c) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ddr_frame_reader.sv
// Reads one frame from DDR as AXI bursts into an output FIFO; one burst outstanding at a time.
// Define DDR_FRAME_READER_CHECK_EN to flag bad rid, misplaced rlast and stray R beats as error.
module ddr_frame_reader
    import ddr_pkg::*;
#(
    parameter logic [DDR_ADDR_W-1:0] FRAME_BASE  = 28'h0000000,
    parameter int unsigned           FRAME_BEATS = 57600,
    parameter int unsigned           BURST_LEN   = 16,
    parameter int unsigned           FIFO_DEPTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    output logic [DDR_ADDR_W-1:0] axi_araddr,
    output logic [DDR_LEN_W-1:0]  axi_arlen,
    output logic [DDR_ID_W-1:0]   axi_aruser_id,
    output logic                  axi_arvalid,
    input  logic                  axi_arready,
    input  logic [DDR_DATA_W-1:0] axi_rdata,
    input  logic [DDR_ID_W-1:0]   axi_rid,
    input  logic                  axi_rlast,
    input  logic                  axi_rvalid,
    output logic [DDR_DATA_W-1:0] o_data,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  error
);

    localparam int unsigned REM_RAW = $clog2(FRAME_BEATS + 1);
    localparam int unsigned LEN_W   = DDR_LEN_W + 1;
    localparam int unsigned REM_W   = (REM_RAW > LEN_W) ? REM_RAW : LEN_W;
    localparam int unsigned FREE_W  = $clog2(FIFO_DEPTH + 1);

    ddr_state_t        state;
    ddr_state_t        state_next;
    ddr_ar_t           ar_q;
    logic [REM_W-1:0]  remaining;
    logic [LEN_W-1:0]  blen;
    logic [LEN_W-1:0]  cur_len_c;
    logic [FREE_W-1:0] fifo_free;
    logic              fifo_empty;
    logic              fifo_full;
    logic              fifo_push_c;
    logic              fifo_pop_c;
    logic              overflow_c;
    logic              room_c;
    logic              load_frame_c;
    logic              issue_c;
    logic              accept_c;
    logic              burst_end_c;
    logic              chk_err_c;

    assign axi_araddr    = ar_q.addr;
    assign axi_arlen     = ar_q.len;
    assign axi_aruser_id = ar_q.user_id;
    assign o_valid       = !fifo_empty;

    assign cur_len_c   = (remaining >= REM_W'(BURST_LEN)) ? LEN_W'(BURST_LEN) : LEN_W'(remaining);
    assign room_c      = 32'(fifo_free) >= 32'(cur_len_c);
    assign fifo_push_c = (state == ST_DATA) && axi_rvalid;
    assign fifo_pop_c  = o_valid && o_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next   = state;
        load_frame_c = 1'b0;
        issue_c      = 1'b0;
        accept_c     = 1'b0;
        burst_end_c  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (frame_start) begin
                    load_frame_c = 1'b1;
                    state_next   = ST_ADDR;
                end
            end
            ST_ADDR: begin
                // Request goes out only once the whole burst is guaranteed a FIFO slot.
                if (axi_arvalid) begin
                    if (axi_arready) begin
                        accept_c   = 1'b1;
                        state_next = ST_DATA;
                    end
                end else if (room_c) begin
                    issue_c = 1'b1;
                end
            end
            ST_DATA: begin
                if (axi_rvalid && axi_rlast) begin
                    burst_end_c = 1'b1;
                    state_next  = (remaining == REM_W'(blen)) ? ST_DONE : ST_ADDR;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ar_q        <= '{addr: FRAME_BASE, len: '0, user_id: '0};
            axi_arvalid <= 1'b0;
            remaining   <= '0;
            blen        <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            error       <= 1'b0;
        end else begin
            busy       <= (state_next != ST_IDLE);
            frame_done <= (state_next == ST_DONE);
            if (load_frame_c) begin
                ar_q.addr <= FRAME_BASE;
                remaining <= REM_W'(FRAME_BEATS);
            end
            if (issue_c) begin
                axi_arvalid <= 1'b1;
                ar_q.len    <= DDR_LEN_W'(cur_len_c - LEN_W'(1));
                blen        <= cur_len_c;
            end
            if (accept_c) begin
                axi_arvalid <= 1'b0;
                ar_q.addr   <= ar_q.addr + ddr_burst_step(blen);
            end
            if (burst_end_c) remaining <= REM_W'(remaining - REM_W'(blen));
            if (overflow_c || chk_err_c) error <= 1'b1;
        end
    end

`ifdef DDR_FRAME_READER_CHECK_EN
    logic [LEN_W-1:0] beat_cnt;
    logic             last_exp_c;

    assign last_exp_c = (beat_cnt == LEN_W'(blen - LEN_W'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              beat_cnt <= '0;
        else if (issue_c)     beat_cnt <= '0;
        else if (fifo_push_c) beat_cnt <= LEN_W'(beat_cnt + LEN_W'(1));
    end

    // rlast must land exactly on the final beat of the requested length.
    assign chk_err_c = axi_rvalid &&
                       ((axi_rid != '0) || (state != ST_DATA) || (axi_rlast != last_exp_c));
`else
    logic unused_rid;
    assign unused_rid = ^axi_rid;
    assign chk_err_c  = 1'b0;
`endif

    ddr_rd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DDR_DATA_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push_c),
        .push_data  (axi_rdata),
        .pop        (fifo_pop_c),
        .rd_data    (o_data),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .free       (fifo_free),
        .overflow_c (overflow_c)
    );

endmodule
